// File: rtl/store_buffer_pkg.sv
// ---------------------------------------------------------------------------
// store_buffer_pkg
//
// Shared definitions for the store buffer and the data memory behind it.
//   - F3_* : load/store size codes carried on funct3.
//   - port_owner_t : which agent owns the single data-memory port this cycle.
//   - load_extract : narrows a 32-bit memory word to a load result,
//                    sign- or zero-extending the low byte/half as funct3 asks.
// ---------------------------------------------------------------------------
package store_buffer_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        PORT_IDLE,
        PORT_LOAD,
        PORT_DRAIN
    } port_owner_t;

    // Memory is word-indexed, so byte and half accesses always use the low lanes.
    function automatic logic [31:0] load_extract(input logic [2:0] funct3,
                                                 input logic [31:0] word);
        logic [31:0] result;
        case (funct3)
            F3_B:    result = {{24{word[7]}}, word[7:0]};
            F3_H:    result = {{16{word[15]}}, word[15:0]};
            F3_BU:   result = {24'h0, word[7:0]};
            F3_HU:   result = {16'h0, word[15:0]};
            default: result = word;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/store_buffer_if.sv
// ---------------------------------------------------------------------------
// store_buffer_if
//
// MEM-stage request bus between the pipeline and the store buffer.
//   req_read / req_write : load / store request (never both)
//   req_funct3           : access size and signedness
//   req_addr             : word address
//   req_wdata            : store data
//   req_rdata            : load result, valid in the request cycle when !stall
//   stall                : request not accepted; the pipeline holds it
// Modports: master = pipeline, slave = store buffer.
// ---------------------------------------------------------------------------
interface store_buffer_if #(
    parameter int ADDR_W = 6
);
    logic              req_read;
    logic              req_write;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [31:0]       req_rdata;
    logic              stall;

    modport master (
        output req_read, req_write, req_funct3, req_addr, req_wdata,
        input  req_rdata, stall
    );

    modport slave (
        input  req_read, req_write, req_funct3, req_addr, req_wdata,
        output req_rdata, stall
    );

endinterface

// File: rtl/store_buffer_fifo.sv
// ---------------------------------------------------------------------------
// sb_fifo
//
// Circular storage for pending stores. Entries are {valid, funct3, addr,
// wdata}; full and empty come from the occupancy count, never from pointer
// equality, so the pointers simply wrap modulo DEPTH.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   push, push_*      enqueue one store at the tail (ignored when full)
//   pop               dequeue the head (ignored when empty)
//   head_*            oldest entry, presented to the memory port on drain
//   entry_valid/addr  every slot, for the load address-match search
//   entry_funct3/wdata every slot, only present when SB_STORE_FWD_EN is set
//   rd_ptr            head index, so the caller can walk entries in age order
//   full, empty       occupancy flags
// ---------------------------------------------------------------------------
module sb_fifo #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 6,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push,
    input  logic [2:0]                    push_funct3,
    input  logic [ADDR_W-1:0]             push_addr,
    input  logic [31:0]                   push_wdata,
    input  logic                          pop,
    output logic [2:0]                    head_funct3,
    output logic [ADDR_W-1:0]             head_addr,
    output logic [31:0]                   head_wdata,
    output logic [DEPTH-1:0]              entry_valid,
    output logic [DEPTH-1:0][ADDR_W-1:0]  entry_addr,
`ifdef SB_STORE_FWD_EN
    output logic [DEPTH-1:0][2:0]         entry_funct3,
    output logic [DEPTH-1:0][31:0]        entry_wdata,
`endif
    output logic [PTR_W-1:0]              rd_ptr,
    output logic                          full,
    output logic                          empty
);

    logic [DEPTH-1:0]             valid_q;
    logic [DEPTH-1:0][2:0]        funct3_q;
    logic [DEPTH-1:0][ADDR_W-1:0] addr_q;
    logic [DEPTH-1:0][31:0]       wdata_q;
    logic [PTR_W-1:0]             wr_ptr_q;
    logic [PTR_W-1:0]             rd_ptr_q;
    logic [PTR_W:0]               count_q;
    logic                         push_ok;
    logic                         pop_ok;

    assign full    = (count_q == (PTR_W+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Control state: valid bits, pointers and count. Reset discards every
    // pending store by clearing valid and count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                valid_q[wr_ptr_q] <= 1'b1;
                wr_ptr_q          <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                valid_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q          <= rd_ptr_q + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Payload storage needs no reset; a slot is only read while its valid
    // bit is set.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            funct3_q[wr_ptr_q] <= push_funct3;
            addr_q[wr_ptr_q]   <= push_addr;
            wdata_q[wr_ptr_q]  <= push_wdata;
        end
    end

    assign head_funct3  = funct3_q[rd_ptr_q];
    assign head_addr    = addr_q[rd_ptr_q];
    assign head_wdata   = wdata_q[rd_ptr_q];
    assign entry_valid  = valid_q;
    assign entry_addr   = addr_q;
`ifdef SB_STORE_FWD_EN
    assign entry_funct3 = funct3_q;
    assign entry_wdata  = wdata_q;
`endif
    assign rd_ptr       = rd_ptr_q;

endmodule

// File: rtl/store_buffer.sv
// ---------------------------------------------------------------------------
// store_buffer
//
// Write buffer between the MEM stage and a word-indexed data memory. Stores
// are queued without stalling while space remains and drained to memory in
// cycles where the pipeline issues nothing. Loads always see every older
// store: a load whose word address matches a pending store stalls while the
// head is force-drained, until no match remains.
//
// Optional feature (macro SB_STORE_FWD_EN): a load whose youngest matching
// store is a full word is answered from the buffer without stalling, and the
// idle port may drain the head in the same cycle.
//
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   req          store_buffer_if.slave MEM-stage request bus
//   dm_read      data memory MemRead
//   dm_write     data memory MemWrite
//   dm_funct3    data memory funct3
//   dm_addr      data memory word address
//   dm_wdata     data memory data_in
//   dm_rdata     data memory data_out (combinational, already extracted)
//   sb_empty     no pending stores
// ---------------------------------------------------------------------------
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    store_buffer_if.slave     req,
    output logic              dm_read,
    output logic              dm_write,
    output logic [2:0]        dm_funct3,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [31:0]       dm_wdata,
    input  logic [31:0]       dm_rdata,
    output logic              sb_empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic                         push;
    logic                         pop;
    logic [2:0]                   head_funct3;
    logic [ADDR_W-1:0]            head_addr;
    logic [31:0]                  head_wdata;
    logic [DEPTH-1:0]             entry_valid;
    logic [DEPTH-1:0][ADDR_W-1:0] entry_addr;
    logic [PTR_W-1:0]             rd_ptr;
    logic                         full;
    logic                         empty;
    logic                         hit;
    port_owner_t                  owner;
`ifdef SB_STORE_FWD_EN
    logic [DEPTH-1:0][2:0]        entry_funct3;
    logic [DEPTH-1:0][31:0]       entry_wdata;
    logic [PTR_W-1:0]             youngest_idx;
`endif

    sb_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .push         (push),
        .push_funct3  (req.req_funct3),
        .push_addr    (req.req_addr),
        .push_wdata   (req.req_wdata),
        .pop          (pop),
        .head_funct3  (head_funct3),
        .head_addr    (head_addr),
        .head_wdata   (head_wdata),
        .entry_valid  (entry_valid),
        .entry_addr   (entry_addr),
`ifdef SB_STORE_FWD_EN
        .entry_funct3 (entry_funct3),
        .entry_wdata  (entry_wdata),
`endif
        .rd_ptr       (rd_ptr),
        .full         (full),
        .empty        (empty)
    );

    // Address-match search over the pending stores. Slots are visited oldest
    // to youngest starting at the head, so the last match seen is the
    // youngest one, which is the value a forwarded load must return.
    // Sub-word stores match on the whole word address (conservative).
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx = '0;
        hit = 1'b0;
`ifdef SB_STORE_FWD_EN
        youngest_idx = '0;
`endif
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PTR_W'(i);
            if (entry_valid[idx] && (entry_addr[idx] == req.req_addr)) begin
                hit = 1'b1;
`ifdef SB_STORE_FWD_EN
                youngest_idx = idx;
`endif
            end
        end
    end

    // Port arbitration and request response. Priority on the single memory
    // port is forced drain, then load, then opportunistic drain. A drain is
    // forced when a store meets a full buffer or a load hits a pending store.
    // Opportunistic drains only take cycles where MEM issues nothing, so a
    // burst of stores fills the buffer before any of it reaches memory.
    // Everything is held quiet while rst_n is low.
    always_comb begin
        owner         = PORT_IDLE;
        push          = 1'b0;
        pop           = 1'b0;
        req.stall     = 1'b0;
        req.req_rdata = 32'h0;
        dm_read       = 1'b0;
        dm_write      = 1'b0;
        dm_funct3     = 3'b000;
        dm_addr       = '0;
        dm_wdata      = 32'h0;

        if (rst_n) begin
            if (req.req_write) begin
                if (full) begin
                    req.stall = 1'b1;
                    owner     = PORT_DRAIN;
                end else begin
                    push = 1'b1;
                end
            end else if (req.req_read) begin
                if (hit) begin
`ifdef SB_STORE_FWD_EN
                    if (entry_funct3[youngest_idx] == F3_W) begin
                        req.req_rdata = load_extract(req.req_funct3,
                                                     entry_wdata[youngest_idx]);
                        owner         = PORT_DRAIN;
                    end else begin
                        req.stall = 1'b1;
                        owner     = PORT_DRAIN;
                    end
`else
                    req.stall = 1'b1;
                    owner     = PORT_DRAIN;
`endif
                end else begin
                    owner         = PORT_LOAD;
                    req.req_rdata = dm_rdata;
                end
            end else if (!empty) begin
                owner = PORT_DRAIN;
            end
        end

        case (owner)
            PORT_LOAD: begin
                dm_read   = 1'b1;
                dm_funct3 = req.req_funct3;
                dm_addr   = req.req_addr;
            end
            PORT_DRAIN: begin
                dm_write  = 1'b1;
                dm_funct3 = head_funct3;
                dm_addr   = head_addr;
                dm_wdata  = head_wdata;
                pop       = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign sb_empty = !rst_n || empty;

endmodule

// File: tb/tb_store_buffer.sv
// ---------------------------------------------------------------------------
// tb_store_buffer
//
// Self-checking bench for store_buffer with a behavioural 64 x 32 data
// memory. Every store the buffer accepts is queued with its expected memory
// write; each dm_write the buffer issues is popped and compared in order.
// Build with +define+SB_STORE_FWD_EN to check the forwarding variant.
// ---------------------------------------------------------------------------
module tb_store_buffer;
    import store_buffer_pkg::*;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 6;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [2:0]        f3;
        logic [31:0]       wdata;
    } exp_t;

    logic              clk;
    logic              rst_n;
    logic              dm_read;
    logic              dm_write;
    logic [2:0]        dm_funct3;
    logic [ADDR_W-1:0] dm_addr;
    logic [31:0]       dm_wdata;
    logic [31:0]       dm_rdata;
    logic              sb_empty;

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];

    store_buffer_if #(.ADDR_W(ADDR_W)) bus();

    store_buffer #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (bus),
        .dm_read   (dm_read),
        .dm_write  (dm_write),
        .dm_funct3 (dm_funct3),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_rdata  (dm_rdata),
        .sb_empty  (sb_empty)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Data memory model: combinational read, posedge write, low-lane sub-words.
    function automatic logic [31:0] mem_init_val(input int i);
        if (i == 54) return 32'd9;
        if (i == 7)  return 32'h1111_2222;
        return 32'hA5A5_0000 | 32'(i);
    endfunction

    function automatic logic [31:0] mem_extract(input logic [2:0] f3, input logic [31:0] w);
        if (f3 == 3'b000) return {{24{w[7]}}, w[7:0]};
        if (f3 == 3'b001) return {{16{w[15]}}, w[15:0]};
        if (f3 == 3'b100) return {24'h0, w[7:0]};
        if (f3 == 3'b101) return {16'h0, w[15:0]};
        return w;
    endfunction

    logic [31:0] mem [64];
    logic        mem_ready = 1'b0;

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 64; i++) mem[i] <= mem_init_val(i);
            mem_ready <= 1'b1;
        end else if (dm_write) begin
            case (dm_funct3)
                3'b000:  mem[dm_addr][7:0]  <= dm_wdata[7:0];
                3'b001:  mem[dm_addr][15:0] <= dm_wdata[15:0];
                default: mem[dm_addr]       <= dm_wdata;
            endcase
        end
    end

    assign dm_rdata = dm_read ? mem_extract(dm_funct3, mem[dm_addr]) : 32'h0;

    // Scoreboard: drains must match accepted stores in order.
    always @(negedge clk) begin
        if (rst_n) begin
            if (dm_write) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL unexpected_drain: got addr %0d data %h, expected no write", dm_addr, dm_wdata);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (dm_addr !== e.addr || dm_wdata !== e.wdata || dm_funct3 !== e.f3) begin
                        failures++;
                        $display("[TB] FAIL drain_order: got addr %0d f3 %0d data %h, expected addr %0d f3 %0d data %h",
                                 dm_addr, dm_funct3, dm_wdata, e.addr, e.f3, e.wdata);
                    end
                end
            end
            if (bus.req_write && !bus.stall)
                exp_q.push_back('{addr: bus.req_addr, f3: bus.req_funct3, wdata: bus.req_wdata});
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [ADDR_W-1:0] a, input logic [31:0] d);
        bus.req_read   = rd;
        bus.req_write  = wr;
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_wdata  = d;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, F3_W, '0, 32'h0);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_store(input logic [2:0] f3, input logic [ADDR_W-1:0] a,
                               input logic [31:0] d, output logic stalled);
        drive(1'b0, 1'b1, f3, a, d);
        @(negedge clk);
        stalled = bus.stall;
        next_cycle();
        idle();
    endtask

    // Holds a load until accepted, counting stall cycles (bounded).
    task automatic issue_load(input logic [2:0] f3, input logic [ADDR_W-1:0] a,
                              output int n_stall, output bit done, output logic [31:0] rdata,
                              output logic rd_seen, output logic wr_seen);
        n_stall = 0;
        done    = 1'b0;
        rdata   = 32'h0;
        rd_seen = 1'b0;
        wr_seen = 1'b0;
        drive(1'b1, 1'b0, f3, a, 32'h0);
        for (int t = 0; t < DEPTH + 4 && !done; t++) begin
            @(negedge clk);
            if (bus.stall) begin
                n_stall++;
            end else begin
                done    = 1'b1;
                rdata   = bus.req_rdata;
                rd_seen = dm_read;
                wr_seen = dm_write;
            end
            next_cycle();
        end
        idle();
    endtask

    task automatic wait_empty(output bit done);
        done = 1'b0;
        idle();
        for (int t = 0; t < 20 && !done; t++) begin
            @(negedge clk);
            if (sb_empty) done = 1'b1;
            next_cycle();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b1, 1'b0, F3_W, 6'd54, 32'h0);
        next_cycle();
        next_cycle();
        @(negedge clk);
        checks++;
        if ({bus.stall, dm_read, dm_write, sb_empty} !== 4'b0001) begin
            failures++;
            $display("[TB] FAIL reset_ctrl: got stall/rd/wr/empty %b expected 0001",
                     {bus.stall, dm_read, dm_write, sb_empty});
        end
        checks++;
        if (bus.req_rdata !== 32'h0) begin
            failures++;
            $display("[TB] FAIL reset_rdata: got %h expected 00000000", bus.req_rdata);
        end
        next_cycle();
        rst_n = 1'b1;
        idle();
        @(negedge clk);
        checks++;
        if (sb_empty !== 1'b1 || dm_write !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_release: got empty %b wr %b expected 1 0", sb_empty, dm_write);
        end
        next_cycle();
    endtask

    task automatic test_single_store();
        logic st;
        drive(1'b0, 1'b1, F3_W, 6'd3, 32'd34);
        @(negedge clk);
        st = bus.stall;
        checks++;
        if (st !== 1'b0 || dm_write !== 1'b0) begin
            failures++;
            $display("[TB] FAIL sw3_accept: got stall %b wr %b expected 0 0", st, dm_write);
        end
        next_cycle();
        idle();
        @(negedge clk);
        checks++;
        if (dm_write !== 1'b1 || dm_addr !== 6'd3 || dm_wdata !== 32'd34) begin
            failures++;
            $display("[TB] FAIL sw3_drain: got wr %b addr %0d data %0d expected 1 3 34", dm_write, dm_addr, dm_wdata);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (sb_empty !== 1'b1 || mem[3] !== 32'd34) begin
            failures++;
            $display("[TB] FAIL sw3_after: got empty %b mem %0d expected 1 34", sb_empty, mem[3]);
        end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        int stall_cycles = 0;
        int first_stall  = -1;
        bit ok;
        bit done;
        for (int k = 0; k < 5; k++) begin
            ok = 1'b0;
            for (int t = 0; t < 4 && !ok; t++) begin
                drive(1'b0, 1'b1, F3_W, 6'(10 + k), 32'hB000_0000 + 32'(k));
                @(negedge clk);
                if (bus.stall) begin
                    stall_cycles++;
                    if (first_stall < 0) first_stall = k;
                end else begin
                    ok = 1'b1;
                end
                next_cycle();
            end
            checks++;
            if (!ok) begin
                failures++;
                $display("[TB] FAIL b2b_accept: store %0d got not accepted expected accepted", k);
            end
        end
        idle();
        checks++;
        if (stall_cycles != 1 || first_stall != 4) begin
            failures++;
            $display("[TB] FAIL b2b_stall: got %0d cycles at store %0d expected 1 at store 4", stall_cycles, first_stall);
        end
        wait_empty(done);
        checks++;
        if (!done) begin
            failures++;
            $display("[TB] FAIL b2b_empty: got busy expected empty");
        end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (mem[10 + k] !== 32'hB000_0000 + 32'(k)) begin
                failures++;
                $display("[TB] FAIL b2b_mem: mem[%0d] got %h expected %h", 10 + k, mem[10 + k], 32'hB000_0000 + 32'(k));
            end
        end
    endtask

    task automatic test_load_after_store();
        logic st, rd, wr;
        logic [31:0] rdata;
        int n;
        bit done;
        issue_store(F3_W, 6'd53, 32'h1234_5680, st);
        issue_load(F3_B, 6'd53, n, done, rdata, rd, wr);
        checks++;
        if (st !== 1'b0 || !done || rdata !== 32'hFFFF_FF80) begin
            failures++;
            $display("[TB] FAIL lb53_data: got stall %b done %0d rdata %h expected 0 1 ffffff80", st, done, rdata);
        end
`ifdef SB_STORE_FWD_EN
        checks++;
        if (n != 0 || rd !== 1'b0) begin
            failures++;
            $display("[TB] FAIL lb53_fwd: got stalls %0d dm_read %b expected 0 0", n, rd);
        end
`else
        checks++;
        if (n != 1 || rd !== 1'b1) begin
            failures++;
            $display("[TB] FAIL lb53_stall: got stalls %0d dm_read %b expected 1 1", n, rd);
        end
`endif
        wait_empty(done);
        checks++;
        if (!done || mem[53] !== 32'h1234_5680) begin
            failures++;
            $display("[TB] FAIL lb53_mem: got %h expected 12345680", mem[53]);
        end
    endtask

    task automatic test_load_miss();
        logic st0, st1, rd, wr;
        logic [31:0] rdata;
        int n;
        bit done;
        issue_store(F3_W, 6'd20, 32'h0000_0020, st0);
        issue_store(F3_W, 6'd21, 32'h0000_0021, st1);
        issue_load(F3_W, 6'd54, n, done, rdata, rd, wr);
        checks++;
        if ({st0, st1} !== 2'b00 || n != 0 || rdata !== 32'd9 || rd !== 1'b1 || wr !== 1'b0) begin
            failures++;
            $display("[TB] FAIL lw54_miss: got stalls %b/%0d rdata %h rd %b wr %b expected 00/0 9 1 0",
                     {st0, st1}, n, rdata, rd, wr);
        end
        wait_empty(done);
        checks++;
        if (!done || mem[20] !== 32'h20 || mem[21] !== 32'h21) begin
            failures++;
            $display("[TB] FAIL lw54_drain: got mem20 %h mem21 %h expected 20 21", mem[20], mem[21]);
        end
    endtask

    task automatic test_sub_word();
        logic st, rd, wr;
        logic [31:0] rdata;
        int n;
        bit done;
        issue_store(F3_H, 6'd7, 32'hDEAD_BEEF, st);
        issue_load(F3_HU, 6'd7, n, done, rdata, rd, wr);
        checks++;
        if (st !== 1'b0 || n != 1 || rdata !== 32'h0000_BEEF || rd !== 1'b1) begin
            failures++;
            $display("[TB] FAIL lhu7: got stalls %0d rdata %h rd %b expected 1 0000beef 1", n, rdata, rd);
        end
        issue_load(F3_W, 6'd7, n, done, rdata, rd, wr);
        checks++;
        if (n != 0 || rdata !== 32'h1111_BEEF) begin
            failures++;
            $display("[TB] FAIL lw7_merge: got stalls %0d rdata %h expected 0 1111beef", n, rdata);
        end
    endtask

    task automatic test_youngest_match();
        logic st0, st1, st2, rd, wr;
        logic [31:0] rdata;
        int n;
        bit done;
        issue_store(F3_W, 6'd30, 32'hAAAA_0030, st0);
        issue_store(F3_H, 6'd31, 32'h0000_5555, st1);
        issue_store(F3_W, 6'd31, 32'hCAFE_F00D, st2);
        issue_load(F3_W, 6'd31, n, done, rdata, rd, wr);
        checks++;
        if ({st0, st1, st2} !== 3'b000 || !done || rdata !== 32'hCAFE_F00D) begin
            failures++;
            $display("[TB] FAIL lw31_data: got rdata %h expected cafef00d", rdata);
        end
`ifdef SB_STORE_FWD_EN
        checks++;
        if (n != 0 || rd !== 1'b0 || wr !== 1'b1) begin
            failures++;
            $display("[TB] FAIL lw31_fwd: got stalls %0d rd %b wr %b expected 0 0 1", n, rd, wr);
        end
`else
        checks++;
        if (n != 3 || rd !== 1'b1) begin
            failures++;
            $display("[TB] FAIL lw31_stall: got stalls %0d rd %b expected 3 1", n, rd);
        end
`endif
        wait_empty(done);
        checks++;
        if (!done || mem[30] !== 32'hAAAA_0030 || mem[31] !== 32'hCAFE_F00D) begin
            failures++;
            $display("[TB] FAIL lw31_mem: got mem30 %h mem31 %h expected aaaa0030 cafef00d", mem[30], mem[31]);
        end
    endtask

    task automatic test_reset_pending();
        logic st;
        for (int k = 0; k < 3; k++) begin
            issue_store(F3_W, 6'(40 + k), 32'h4000_0000 + 32'(k), st);
            checks++;
            if (st !== 1'b0) begin
                failures++;
                $display("[TB] FAIL rst_fill: store %0d got stall 1 expected 0", k);
            end
        end
        rst_n = 1'b0;
        idle();
        exp_q.delete();
        @(negedge clk);
        checks++;
        if ({bus.stall, dm_write, sb_empty} !== 3'b001) begin
            failures++;
            $display("[TB] FAIL rst_mid: got stall/wr/empty %b expected 001", {bus.stall, dm_write, sb_empty});
        end
        next_cycle();
        rst_n = 1'b1;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            checks++;
            if (dm_write !== 1'b0 || sb_empty !== 1'b1) begin
                failures++;
                $display("[TB] FAIL rst_discard: cycle %0d got wr %b empty %b expected 0 1", t, dm_write, sb_empty);
            end
            next_cycle();
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (mem[40 + k] !== mem_init_val(40 + k)) begin
                failures++;
                $display("[TB] FAIL rst_mem: mem[%0d] got %h expected %h", 40 + k, mem[40 + k], mem_init_val(40 + k));
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        test_reset();
        test_single_store();
        test_back_to_back();
        test_load_after_store();
        test_load_miss();
        test_sub_word();
        test_youngest_match();
        test_reset_pending();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_left: got %0d pending writes expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- FIFO write buffer between the MEM pipeline stage and the data memory (word-indexed, 64 x 32, combinational read, posedge write, funct3 byte/half/word lanes).
- Accepts stores from MEM without stalling while space remains.
- Drains stores to memory in idle memory-port cycles.
- Guarantees loads observe all older stores, by stalling or by forwarding.

Parameters:
- DEPTH, 4, number of buffered stores; power of two, at least 2.
- ADDR_W, 6, word-address width into data memory.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- req_read  in  1  MEM-stage load request.
- req_write  in  1  MEM-stage store request; never asserted together with req_read.
- req_funct3  in  3  load/store size/sign code (000 B, 001 H, 010 W, 100 BU, 101 HU).
- req_addr  in  ADDR_W  word address.
- req_wdata  in  32  store data.
- req_rdata  out  32  load result, valid in the same cycle as req_read when stall=0.
- stall  out  1  request not accepted this cycle; the pipeline holds the MEM request.
- dm_read  out  1  to data memory MemRead.
- dm_write  out  1  to data memory MemWrite.
- dm_funct3  out  3  to data memory funct3.
- dm_addr  out  ADDR_W  to data memory addr.
- dm_wdata  out  32  to data memory data_in.
- dm_rdata  in  32  from data memory data_out (combinational).
- sb_empty  out  1  no pending stores (used by fence/halt logic).

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-low on rst_n.
- Storage: circular FIFO of DEPTH entries {valid, funct3, addr, wdata}; write pointer, read pointer, count of log2(DEPTH)+1 bits.
- Reset (rst_n=0 at posedge): count=0, pointers=0, all valid=0, pending stores discarded.
- While rst_n=0: stall=0, dm_read=0, dm_write=0, req_rdata=0, sb_empty=1.
- Memory port is single-issue per cycle. Priority: forced drain > load > opportunistic drain.
- Store accept:
  - req_write with count<DEPTH: enqueue at posedge, stall=0.
  - count==DEPTH: stall=1 and the head drains this cycle. No accept in the same cycle; the store is accepted the next cycle.
- Drain:
  - When count>0 and no load is using the port, present the head entry on dm_* with dm_write=1.
  - Dequeue at the same posedge (memory write happens at that edge).
  - Enqueue and dequeue in the same cycle: count unchanged.
- Load, no address match among valid entries:
  - dm_read=1, dm_addr=req_addr, dm_funct3=req_funct3.
  - req_rdata=dm_rdata combinationally; stall=0; no drain that cycle.
- Load hit (any valid entry with addr==req_addr):
  - stall=1, forced drain of the head each cycle until no match remains.
  - Then the load proceeds as above. Worst-case latency is DEPTH extra cycles.
- With no request, drain runs every cycle until empty.
- Pointer wrap: modulo DEPTH. Full/empty are distinguished by count, not by pointer equality.
- sb_empty = (count==0), registered-state derived.
- Address match compares the full ADDR_W bits. Sub-word stores are matched at word granularity (conservative).

Optional Feature:
- Macro: SB_STORE_FWD_EN.
- Defined:
  - On a load hit whose youngest matching entry is a word store (funct3=010), req_rdata is taken from that entry's wdata.
  - funct3 extraction is applied: LB/LH sign-extend bits [7:0]/[15:0]; LBU/LHU zero-extend.
  - stall=0, dm_read=0, and an opportunistic drain may use the port that cycle.
  - If the youngest match is SB/SH, the block stalls as in the base behaviour.
- Undefined: every load hit stalls; no forwarding logic is synthesised.

Decomposition:
- Shared package holds the funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU) and a load-extract function (funct3, word to 32-bit result).
- Both this block and the data memory use the package.
- One sub-module, sb_fifo: storage, pointers, count, full/empty.
- Match, arbitration and forwarding stay in store_buffer.

Test Plan:
- Reset, then SW addr 3 data 34, then idle 1 cycle -> stall=0 on the store; dm_write=1, dm_addr=3, dm_wdata=34 the next cycle; sb_empty=1 after.
- 5 back-to-back SW to addrs 10..14 with DEPTH=4, no loads -> 5th store sees stall=1 for exactly 1 cycle; memory ends with mem[10..14] = the written data in order.
- SW addr 53 data 0x1234_5680, then LB addr 53 in the next cycle:
  - Base build -> stall=1 until drained, then req_rdata=0xFFFF_FF80.
  - SB_STORE_FWD_EN build -> stall=0, req_rdata=0xFFFF_FF80, dm_read=0.
- Load from addr 54 (holds 9) while 2 stores to addrs 20/21 are pending -> req_rdata=9, stall=0, no drain that cycle; stores drain afterwards.
- SH addr 7 then LHU addr 7 with SB_STORE_FWD_EN -> stall until drained (sub-word match), then req_rdata=zero-extended low half.
- rst_n=0 for one edge with 3 stores pending -> count=0, sb_empty=1, no dm_write after reset; memory contents unchanged.
